// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit holding the HI/LO register pair.
// It latches the result at Start and commits it to HI/LO after a fixed number of busy cycles.
module mult_div #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  input  logic        HiLoSel,
  output logic        Busy,
  output logic [31:0] HILO_out
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, r_lo, r_res_hi, r_res_lo;
  logic [31:0] w_hi_nxt, w_lo_nxt, w_res_hi_nxt, w_res_lo_nxt;

  logic        w_start_mul, w_start_div;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_quo, w_rem;

  assign w_start_mul = Start && (MDOp == OP_MULT || MDOp == OP_MULTU);
  assign w_start_div = Start && (MDOp == OP_DIV  || MDOp == OP_DIVU);

  assign w_prod_s = $signed(D1) * $signed(D2);
  assign w_prod_u = {32'd0, D1} * {32'd0, D2};

  // Divide by zero re-latches the current HI/LO so completion writes them back unchanged.
  always_comb begin
    w_quo = r_lo;
    w_rem = r_hi;
    if (D2 != 32'd0) begin
      if (MDOp == OP_DIVU) begin
        w_quo = D1 / D2;
        w_rem = D1 % D2;
      end else if (D1 == 32'h8000_0000 && D2 == 32'hFFFF_FFFF) begin
        w_quo = 32'h8000_0000;
        w_rem = 32'd0;
      end else begin
        w_quo = $signed(D1) / $signed(D2);
        w_rem = $signed(D1) % $signed(D2);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_res_hi_nxt = r_res_hi;
    w_res_lo_nxt = r_res_lo;
    unique case (r_state)
      IDLE: begin
        if (w_start_mul) begin
          {w_res_hi_nxt, w_res_lo_nxt} = (MDOp == OP_MULT) ? w_prod_s : w_prod_u;
          w_cnt_nxt   = MULT_CNT;
          w_state_nxt = MUL;
        end else if (w_start_div) begin
          w_res_lo_nxt = w_quo;
          w_res_hi_nxt = w_rem;
          w_cnt_nxt    = DIV_CNT;
          w_state_nxt  = DIV;
        end else if (MDOp == OP_MTHI) begin
          w_hi_nxt = D1;
        end else if (MDOp == OP_MTLO) begin
          w_lo_nxt = D1;
        end
      end
      MUL, DIV: begin
        if (r_cnt <= 4'd1) begin
          w_hi_nxt    = r_res_hi;
          w_lo_nxt    = r_res_lo;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: the result latches are reset too, so an aborted operation leaves nothing to commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_res_hi <= w_res_hi_nxt;
      r_res_lo <= w_res_lo_nxt;
    end
  end

  assign Busy     = (r_state != IDLE);
  assign HILO_out = HiLoSel ? r_hi : r_lo;

endmodule

// File: tb/tb_mult_div.sv
// Directed table-driven bench for mult_div plus hand sequences for overlap, reset and
// completion-edge corner cases.
module tb_mult_div;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] D1, D2;
  logic [2:0]  MDOp;
  logic        Start, HiLoSel;
  logic        Busy;
  logic [31:0] HILO_out;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .D1(D1), .D2(D2), .MDOp(MDOp), .Start(Start),
    .HiLoSel(HiLoSel), .Busy(Busy), .HILO_out(HILO_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] d1, d2, hi, lo;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    HiLoSel = 1'b1; #1; hi = HILO_out;
    HiLoSel = 1'b0; #1; lo = HILO_out;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    Start = 1'b1; MDOp = op; D1 = a; D2 = b;
    step();
    Start = 1'b0; MDOp = 3'b000;
    cyc = 0;
    while (Busy && cyc < 100) begin
      cyc++;
      step();
    end
  endtask

  task automatic write_hl(input logic [2:0] op, input logic [31:0] val);
    MDOp = op; D1 = val;
    step();
    MDOp = 3'b000;
  endtask

  initial begin
    logic [31:0] hi, lo;
    int cyc;

    vecs[0] = '{"mult_neg",     3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{"multu_big",    3'b010, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{"div_neg",      3'b011, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{"divu_zero",    3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4] = '{"divu_7_2",     3'b100, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 10};
    vecs[5] = '{"div_pos_neg",  3'b011, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[6] = '{"mult_2p32",    3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
    vecs[7] = '{"mult_minsq",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[8] = '{"multu_maxsq",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[9] = '{"div_neg_neg",  3'b011, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 10};

    reset = 1'b1; Start = 1'b0; MDOp = 3'b000; D1 = '0; D2 = '0; HiLoSel = 1'b0;
    #2;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    read_hilo(hi, lo);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].d1, vecs[i].d2, cyc);
      check({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].cyc));
      read_hilo(hi, lo);
      check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
    end

    // Start with an unsupported op code must not start anything.
    Start = 1'b1; MDOp = 3'b111; step();
    check("start_op111_busy", {31'd0, Busy}, 32'd0);
    MDOp = 3'b000; step();
    check("start_op000_busy", {31'd0, Busy}, 32'd0);
    Start = 1'b0;

    // mthi / mtlo visible the cycle after the edge.
    write_hl(3'b101, 32'h1234_5678);
    HiLoSel = 1'b1; #1;
    check("mthi", HILO_out, 32'h1234_5678);
    write_hl(3'b110, 32'h0000_0055);
    HiLoSel = 1'b0; #1;
    check("mtlo", HILO_out, 32'h0000_0055);

    // Overflow divide with an ignored second Start and an ignored mtlo while busy.
    Start = 1'b1; MDOp = 3'b011; D1 = 32'h8000_0000; D2 = 32'hFFFF_FFFF;
    step();
    Start = 1'b0; MDOp = 3'b000;
    cyc = 0;
    while (Busy && cyc < 100) begin
      cyc++;
      if (cyc == 3) begin
        Start = 1'b1; MDOp = 3'b001; D1 = 32'd2; D2 = 32'd3;
      end
      if (cyc == 5) begin
        MDOp = 3'b110; D1 = 32'h0000_DEAD;
      end
      if (cyc == 10) begin
        HiLoSel = 1'b0; #1;
        check("ovf_lo_before_commit", HILO_out, 32'h0000_0055);
      end
      step();
      Start = 1'b0; MDOp = 3'b000;
    end
    check("ovf_cycles", 32'(cyc), 32'd10);
    read_hilo(hi, lo);
    check("ovf_hi", hi, 32'd0);
    check("ovf_lo", lo, 32'h8000_0000);
    step();
    check("ovf_no_restart", {31'd0, Busy}, 32'd0);

    // mthi on the completion edge loses to the write-back.
    Start = 1'b1; MDOp = 3'b001; D1 = 32'h10; D2 = 32'h10;
    step();
    Start = 1'b0; MDOp = 3'b000;
    repeat (4) step();
    MDOp = 3'b101; D1 = 32'h0000_0BAD;
    step();
    MDOp = 3'b000;
    check("cmpl_busy", {31'd0, Busy}, 32'd0);
    read_hilo(hi, lo);
    check("cmpl_hi", hi, 32'd0);
    check("cmpl_lo", lo, 32'h100);

    // Reset in the middle of a multiply.
    write_hl(3'b101, 32'h0000_0777);
    Start = 1'b1; MDOp = 3'b001; D1 = 32'd5; D2 = 32'd6;
    step();
    Start = 1'b0; MDOp = 3'b000;
    step();
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, Busy}, 32'd0);
    read_hilo(hi, lo);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    step();
    reset = 1'b0;
    repeat (8) step();
    check("rst_after_busy", {31'd0, Busy}, 32'd0);
    read_hilo(hi, lo);
    check("rst_after_hi", hi, 32'd0);
    check("rst_after_lo", lo, 32'd0);

    // Start on the first edge after reset release.
    reset = 1'b1;
    step();
    reset = 1'b0;
    run_op(3'b001, 32'd3, 32'd4, cyc);
    check("post_rst_cycles", 32'(cyc), 32'd5);
    read_hilo(hi, lo);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL provide port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port D1  input  32  rs operand from E stage (already forwarded).
REQ-006 SHALL provide port D2  input  32  rt operand from E stage (already forwarded).
REQ-007 SHALL provide port MDOp  input  3  op code: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-008 SHALL provide port Start  input  1  one-cycle strobe; E-stage instruction is mult/multu/div/divu.
REQ-009 SHALL provide port HiLoSel  input  1  read select: 0 LO, 1 HI.
REQ-010 SHALL provide port Busy  output  1  high while an operation is in progress; goes to the hazard unit with Start.
REQ-011 SHALL provide port HILO_out  output  32  HiLoSel ? HI : LO, combinational, for mfhi/mflo.

Function
REQ-012 SHALL hold state IDLE, MUL or DIV, plus a 4-bit down-counter cnt, 32-bit HI, 32-bit LO, and latched result registers res_hi/res_lo.
REQ-013 SHALL drive Busy = (state != IDLE) as a registered value; Start itself SHALL NOT raise Busy combinationally.
REQ-014 IDLE with Start=1 and MDOp in {001,010} at an edge SHALL compute the 64-bit product into res_hi:res_lo, load cnt=MULT_CYCLES and go to MUL.
REQ-015 Signedness: mult SHALL multiply as signed 32x32 to 64; multu SHALL multiply as unsigned.
REQ-016 IDLE with Start=1 and MDOp in {011,100} at an edge SHALL latch quotient into res_lo and remainder into res_hi, load cnt=DIV_CYCLES and go to DIV.
REQ-017 div SHALL truncate toward zero, and the remainder SHALL take the dividend's sign; divu SHALL be unsigned.
REQ-018 Overflow: div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-019 Divide by zero (D2==0) SHALL leave HI/LO unchanged at completion, while still taking the full DIV_CYCLES of Busy.
REQ-020 In MUL/DIV, each edge SHALL decrement cnt; at the edge where cnt==1, HI<=res_hi, LO<=res_lo, cnt->0 and state->IDLE.
REQ-021 Busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles after the Start edge, and the new HI/LO become visible in the same cycle Busy falls.
REQ-022 Start=1 while Busy=1 SHALL be ignored, with no state change.
REQ-023 Start=1 with MDOp not in 001..100 SHALL be ignored.
REQ-024 MDOp=101 (mthi) in IDLE SHALL write HI<=D1 at the edge; MDOp=110 (mtlo) in IDLE SHALL write LO<=D1 at the edge. Start is not required for either.
REQ-025 mthi/mtlo arriving while Busy SHALL be ignored.
REQ-026 mthi/mtlo coinciding with a completion edge SHALL be ignored, and the completion write SHALL win.
REQ-027 HILO_out SHALL reflect HI/LO as currently registered; there is no bypass of an in-flight result.
REQ-028 Stalling mfhi/mflo/mult/div/mt* while Start||Busy is the hazard unit's job; this block does not stall.

Reset
REQ-029 reset=1 SHALL asynchronously force HI=0, LO=0, res_hi=0, res_lo=0, cnt=0, state=IDLE, Busy=0, HILO_out=0, including in the middle of an operation.
REQ-030 An operation aborted by reset SHALL NOT write HI/LO after reset is released.
REQ-031 The first edge after reset deassertion SHALL accept Start normally.

Verification
REQ-032 mult: Start, MDOp=001, D1=0xFFFFFFFE, D2=3 -> Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
REQ-033 multu: D1=0xFFFFFFFF, D2=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 div: D1=0xFFFFFFF9 (-7), D2=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> HI/LO unchanged after 10 cycles.
REQ-035 Overflow div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; second Start at Busy cycle 3 ignored, and Busy falls exactly 10 cycles after the first Start edge.
REQ-036 mthi D1=0x12345678, HiLoSel=1 -> HILO_out=0x12345678 next cycle; mtlo during Busy ignored.
REQ-037 reset asserted at Busy cycle 2 of mult -> Busy, HI, LO immediately 0, and no write-back afterwards.
